nn_seq_classifier: RTL
======================

# nn_seq_classifier

Time-multiplexed, parametrised two-layer perceptron classifier: the successor of the fixed 4-4-3 fully parallel iris network. A single signed fixed-point multiply-accumulate unit is shared across all neurons, with a PLAN sigmoid and a running argmax. Weights are loaded at run time through a write port, and samples enter and results leave through valid/ready handshakes. It sits between the switch/input front end and the display/result logic.

## Interface
- N_IN, 4, number of input features
- N_HID, 4, hidden-layer neurons
- N_OUT, 3, output classes (2..16)
- IN_W, 4, unsigned width of each input feature
- DW, 16, signed data/weight width, Q(DW-8).8
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  weight write strobe
- wr_addr  in  8  weight address (layout below)
- wr_data  in  DW  weight/bias value, Q8.8
- in_valid  in  1  sample valid
- in_ready  out  1  block can accept a sample (high only in IDLE)
- in_feat  in  N_IN*IN_W  packed features, feature 0 in LSBs
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- species  out  4  winning class index
- score  out  DW  winning sigmoid value, Q8.8

## Operation
- Weight layout: hidden W[h][i] at h*N_IN+i; hidden bias at N_HID*N_IN+h; output W[o][h] at base B1=N_HID*(N_IN+1), address B1+o*N_HID+h; output bias at B1+N_OUT*N_HID+o. Default total 35 entries.
- Writes take effect only in IDLE. Writes in other states, and writes to addresses beyond the last entry, are dropped.
- Input conversion: feature value v becomes v<<8 (Q8.8).
- FSM states: IDLE -> HMAC -> HACT -> (next hidden neuron: HMAC, or after the last one: OMAC) -> OACT -> (next output neuron: OMAC, or after the last one: DONE) -> IDLE.
- Accept: in_valid & in_ready latches in_feat. The state goes to HMAC with neuron index 0 and term index 0.
- MAC cycle k: acc = (k==0 ? bias : acc) + ((w*x)>>>8). The product is full 2*DW wide. acc has DW+8 bits of headroom.
- ACT cycle:
  - Saturate acc to DW bits.
  - Apply PLAN on |x|: |x|>=5.0 gives 1.0; 2.375<=|x|<5 gives |x|>>5 + 0.84375; 1<=|x|<2.375 gives |x|>>3 + 0.625; otherwise |x|>>2 + 0.5.
  - For x<0, the result is 1.0-y. All shifts truncate.
  - Hidden results go to h[]. Output results update the argmax.
- Argmax uses strictly greater-than, so ties keep the lower index. It is initialised from output 0.
- DONE: out_valid=1, and species/score are stable. out_ready moves the state to IDLE. in_ready is low in DONE, so a sample is never accepted in the same cycle as out_ready.
- Reset (any time, including mid-computation) does all of the following:
  - aborts the computation and sets the state to IDLE;
  - clears all weights to 0;
  - drives in_ready=1, out_valid=0, species=0, score=0.

## Timing
- Hidden neuron: N_IN MAC cycles plus 1 ACT cycle. Output neuron: N_HID MAC cycles plus 1 ACT cycle.
- Latency L = N_HID*(N_IN+1) + N_OUT*(N_HID+1). out_valid rises on the L-th rising edge after the accepting edge. Default L = 35.
- in_ready falls on the accepting edge and rises again on the edge that consumes the result.
- Minimum sample period is L+2 cycles (L, plus 1 DONE cycle with out_ready high, plus 1 IDLE cycle).
- species and score change only on the edge entering DONE and hold until the next DONE.
- The weight write is registered, so a write is visible to a sample accepted on the following edge.

## Test plan
- Reset, then zero weights, then input 4,4,4,4 -> after exactly 35 cycles out_valid=1, species=0, score=128 (all outputs tie at 0.5).
- W[0][0]=256 (address 0), output W[0][0]=256 (address 20), input sl=4 -> h0=248, species=0, score=190.
- Output bias 2=1280 (address 34), everything else 0 -> species=2, score=256. Then set output bias 2=-1280 -> species=0, score=128.
- Hold out_ready=0 for 10 cycles after out_valid -> out_valid, species and score are stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> in_ready=1 on the next cycle.
- Write address 20 while busy -> the write is dropped (the result matches the pre-write weights). Write address 200 in IDLE -> no effect.
- Assert rst at cycle 12 of a computation -> all outputs are at reset values immediately. The next sample with no reload yields score=128, species=0.

Source files
------------

// File: rtl/nn_seq_classifier.sv
// Two-layer perceptron classifier time-multiplexed over one signed Q8.8 MAC unit.
// Weights are loaded at run time; samples and results move through valid/ready handshakes.
module nn_seq_classifier #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 3,
    parameter int IN_W  = 4,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [7:0]           wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_feat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           species,
    output logic [DW-1:0]        score
);

    localparam int B1 = N_HID * (N_IN + 1);
    localparam int NW = B1 + N_OUT * (N_HID + 1);
    localparam int AW = DW + 8;

    localparam logic [7:0] LAST_IN  = 8'(N_IN - 1);
    localparam logic [7:0] LAST_HID = 8'(N_HID - 1);
    localparam logic [7:0] LAST_OUT = 8'(N_OUT - 1);
    localparam logic [7:0] NW8      = 8'(NW);
    localparam logic [7:0] NIN8     = 8'(N_IN);
    localparam logic [7:0] NHID8    = 8'(N_HID);
    localparam logic [7:0] B1_8     = 8'(B1);
    localparam logic [7:0] HB8      = 8'(N_HID * N_IN);
    localparam logic [7:0] OB8      = 8'(B1 + N_OUT * N_HID);

    localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (DW - 1)));

    localparam logic [DW:0] T_SAT   = (DW+1)'(5 * 256);
    localparam logic [DW:0] T_MID   = (DW+1)'(608);
    localparam logic [DW:0] ONE     = (DW+1)'(256);
    localparam logic [DW:0] C_MID   = (DW+1)'(216);
    localparam logic [DW:0] C_LOW   = (DW+1)'(160);
    localparam logic [DW:0] C_SMALL = (DW+1)'(128);

    // IDLE wait sample | HMAC/OMAC accumulate one term | HACT/OACT sigmoid | DONE hold result
    typedef enum logic [2:0] {IDLE, HMAC, HACT, OMAC, OACT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             neu_q, neu_d, term_q, term_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [N_IN*IN_W-1:0]   feat_q, feat_d;
    logic [3:0]             best_idx_q, best_idx_d, species_q, species_d;
    logic signed [DW-1:0]   best_sc_q, best_sc_d, score_q, score_d;
    logic signed [DW-1:0]   w_q [NW];
    logic signed [DW-1:0]   h_q [N_HID];

    logic [7:0]             widx, bidx;
    logic signed [DW-1:0]   w_sel, b_sel, x_sel;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   mac_term, acc_sum;
    logic signed [DW-1:0]   sat_x, act_y;
    logic signed [DW:0]     sx;
    logic [DW:0]            ax, y_pos, y_full;
    logic                   h_we, better, wr_ok;

    always_comb begin
        if (state_q == OMAC) begin
            widx = B1_8 + neu_q * NHID8 + term_q;
            bidx = OB8 + neu_q;
        end else begin
            widx = neu_q * NIN8 + term_q;
            bidx = HB8 + neu_q;
        end
        w_sel = '0;
        b_sel = '0;
        for (int j = 0; j < NW; j++) begin
            if (widx == 8'(j)) w_sel = w_q[j];
            if (bidx == 8'(j)) b_sel = w_q[j];
        end
        x_sel = '0;
        if (state_q == OMAC) begin
            for (int i = 0; i < N_HID; i++)
                if (term_q == 8'(i)) x_sel = h_q[i];
        end else begin
            for (int i = 0; i < N_IN; i++)
                if (term_q == 8'(i)) x_sel = DW'({feat_q[i*IN_W +: IN_W], 8'b0});
        end
        prod     = w_sel * x_sel;
        mac_term = AW'(prod >>> 8);
        acc_sum  = ((term_q == 8'd0) ? AW'(b_sel) : acc_q) + mac_term;
    end

    // Piecewise-linear sigmoid evaluated on |x|, mirrored for negative inputs.
    always_comb begin
        if (acc_q > SMAX)      sat_x = DW'(SMAX);
        else if (acc_q < SMIN) sat_x = DW'(SMIN);
        else                   sat_x = DW'(acc_q);
        sx = {sat_x[DW-1], sat_x};
        ax = sx[DW] ? -sx : sx;
        if (ax >= T_SAT)      y_pos = ONE;
        else if (ax >= T_MID) y_pos = (ax >> 5) + C_MID;
        else if (ax >= ONE)   y_pos = (ax >> 3) + C_LOW;
        else                  y_pos = (ax >> 2) + C_SMALL;
        y_full = sx[DW] ? ONE - y_pos : y_pos;
        act_y  = DW'(y_full);
        better = (neu_q == 8'd0) || (act_y > best_sc_q);
    end

    always_comb begin
        state_d    = state_q;
        neu_d      = neu_q;
        term_d     = term_q;
        acc_d      = acc_q;
        feat_d     = feat_q;
        best_idx_d = best_idx_q;
        best_sc_d  = best_sc_q;
        species_d  = species_q;
        score_d    = score_q;
        h_we       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    feat_d  = in_feat;
                    neu_d   = '0;
                    term_d  = '0;
                    state_d = HMAC;
                end
            end
            HMAC: begin
                acc_d = acc_sum;
                if (term_q == LAST_IN) begin
                    term_d  = '0;
                    state_d = HACT;
                end else begin
                    term_d = term_q + 8'd1;
                end
            end
            HACT: begin
                h_we = 1'b1;
                if (neu_q == LAST_HID) begin
                    neu_d   = '0;
                    state_d = OMAC;
                end else begin
                    neu_d   = neu_q + 8'd1;
                    state_d = HMAC;
                end
            end
            OMAC: begin
                acc_d = acc_sum;
                if (term_q == LAST_HID) begin
                    term_d  = '0;
                    state_d = OACT;
                end else begin
                    term_d = term_q + 8'd1;
                end
            end
            OACT: begin
                if (better) begin
                    best_idx_d = 4'(neu_q);
                    best_sc_d  = act_y;
                end
                if (neu_q == LAST_OUT) begin
                    species_d = better ? 4'(neu_q) : best_idx_q;
                    score_d   = better ? act_y : best_sc_q;
                    neu_d     = '0;
                    state_d   = DONE;
                end else begin
                    neu_d   = neu_q + 8'd1;
                    state_d = OMAC;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ok   = wr_en && (state_q == IDLE) && (wr_addr < NW8);
    assign species = species_q;
    assign score   = score_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            neu_q      <= '0;
            term_q     <= '0;
            acc_q      <= '0;
            feat_q     <= '0;
            best_idx_q <= '0;
            best_sc_q  <= '0;
            species_q  <= '0;
            score_q    <= '0;
            for (int j = 0; j < NW; j++) w_q[j] <= '0;
            for (int i = 0; i < N_HID; i++) h_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            neu_q      <= neu_d;
            term_q     <= term_d;
            acc_q      <= acc_d;
            feat_q     <= feat_d;
            best_idx_q <= best_idx_d;
            best_sc_q  <= best_sc_d;
            species_q  <= species_d;
            score_q    <= score_d;
            if (wr_ok)
                for (int j = 0; j < NW; j++)
                    if (wr_addr == 8'(j)) w_q[j] <= wr_data;
            if (h_we)
                for (int i = 0; i < N_HID; i++)
                    if (neu_q == 8'(i)) h_q[i] <= act_y;
        end
    end

endmodule
